// File: rtl/mcu_channel_aligner_pkg.sv
// Shared types and constants for the MCU channel aligner: channel/mode codes,
// the 8x8 block payload type and the Y-blocks-per-MCU lookup.
package mcu_channel_aligner_pkg;

  localparam int unsigned Q      = 8;
  localparam int unsigned MAX_Y  = 4;
  localparam int unsigned YCNT_W = 3;

  localparam logic [1:0] CH_Y  = 2'd0;
  localparam logic [1:0] CH_CB = 2'd1;
  localparam logic [1:0] CH_CR = 2'd2;

  localparam logic [1:0] MODE_444  = 2'd0;
  localparam logic [1:0] MODE_422  = 2'd1;
  localparam logic [1:0] MODE_420  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef logic [7:0][7:0][Q-1:0] block_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

  function automatic logic [YCNT_W-1:0] n_y_blocks(input logic [1:0] mode);
    case (mode)
      MODE_422: return YCNT_W'(2);
      MODE_420: return YCNT_W'(4);
      default:  return YCNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/mcu_channel_aligner_chroma_upsample.sv
// Nearest-neighbour chroma upsampler: picks the quadrant/half of one chroma
// block that lines up with Y block k for the given chroma mode.
module mcu_channel_aligner_chroma_upsample
  import mcu_channel_aligner_pkg::*;
(
  input  block_t     c,
  input  logic [1:0] mode,
  input  logic [1:0] k,
  output block_t     up
);

  function automatic logic [2:0] src_row(input logic [1:0] m, input logic [1:0] kk,
                                         input logic [2:0] r);
    return (m == MODE_420) ? {kk[1], r[2:1]} : r;
  endfunction

  function automatic logic [2:0] src_col(input logic [1:0] m, input logic [1:0] kk,
                                         input logic [2:0] col);
    return (m == MODE_422 || m == MODE_420) ? {kk[0], col[2:1]} : col;
  endfunction

  always_comb begin
    up = '0;
    for (int r = 0; r < 8; r++) begin
      for (int col = 0; col < 8; col++) begin
        up[3'(r)][3'(col)] = c[src_row(mode, k, 3'(r))][src_col(mode, k, 3'(col))];
      end
    end
  end

endmodule

// File: rtl/mcu_channel_aligner.sv
// Collects one MCU (nY Y blocks, Cb, Cr) and emits one aligned Y/Cb/Cr triple
// per Y block with upsampled chroma over a valid/ready handshake.
module mcu_channel_aligner
  import mcu_channel_aligner_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_in,
  input  block_t     blk_in,
  input  logic [1:0] ch_in,
  input  logic       in_valid,
  output logic       in_ready,
  output block_t     y_out,
  output block_t     cb_out,
  output block_t     cr_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_idx,
  output logic       mcu_last,
  output logic       seq_err
);

  state_e              state_q, state_d;
  logic [YCNT_W-1:0]   ycnt_q, ycnt_d;
  logic                cb_held_q, cb_held_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          k_q, k_d;

  logic                y_we, cb_we, cr_we, load_out, err_d, last_d;
  logic                mcu_start;
  logic [1:0]          mode_in_eff, eff_mode, exp_ch;
  logic [YCNT_W-1:0]   ny;

  block_t              ybuf [MAX_Y];
  block_t              cb_buf, cr_buf, cr_src, cb_up, cr_up;

  // State and collection counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_COLLECT;
      ycnt_q    <= '0;
      cb_held_q <= 1'b0;
      mode_q    <= MODE_444;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      ycnt_q    <= ycnt_d;
      cb_held_q <= cb_held_d;
      mode_q    <= mode_d;
      k_q       <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ycnt_d    = ycnt_q;
    cb_held_d = cb_held_q;
    mode_d    = mode_q;
    k_d       = k_q;
    y_we      = 1'b0;
    cb_we     = 1'b0;
    cr_we     = 1'b0;
    load_out  = 1'b0;
    err_d     = 1'b0;

    // Mode comes straight from mode_in only until the MCU's first block lands
    mcu_start   = (ycnt_q == '0) && !cb_held_q;
    mode_in_eff = (mode_in == MODE_RSVD) ? MODE_444 : mode_in;
    eff_mode    = mcu_start ? mode_in_eff : mode_q;
    ny          = n_y_blocks(eff_mode);

    if (ycnt_q < ny)     exp_ch = CH_Y;
    else if (!cb_held_q) exp_ch = CH_CB;
    else                 exp_ch = CH_CR;

    case (state_q)
      ST_COLLECT: begin
        if (in_valid) begin
          if (ch_in != exp_ch) begin
            err_d = 1'b1;
          end else begin
            case (exp_ch)
              CH_Y: begin
                y_we   = 1'b1;
                ycnt_d = ycnt_q + YCNT_W'(1);
                if (mcu_start) begin
                  mode_d = mode_in_eff;
                  err_d  = (mode_in == MODE_RSVD);
                end
              end
              CH_CB: begin
                cb_we     = 1'b1;
                cb_held_d = 1'b1;
              end
              default: begin
                cr_we    = 1'b1;
                state_d  = ST_EMIT;
                k_d      = '0;
                load_out = 1'b1;
              end
            endcase
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if ({1'b0, k_q} == ny - YCNT_W'(1)) begin
            state_d   = ST_COLLECT;
            ycnt_d    = '0;
            cb_held_d = 1'b0;
            k_d       = '0;
          end else begin
            k_d      = k_q + 2'd1;
            load_out = 1'b1;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    last_d = (state_d == ST_EMIT) && ({1'b0, k_d} == ny - YCNT_W'(1));
  end

  // Block storage; stale contents are harmless because counters gate reuse
  always_ff @(posedge clk) begin
    if (y_we)  ybuf[ycnt_q[1:0]] <= blk_in;
    if (cb_we) cb_buf <= blk_in;
    if (cr_we) cr_buf <= blk_in;
  end

  // Cr is not yet stored on the edge that loads the first triple
  assign cr_src = (state_q == ST_COLLECT) ? blk_in : cr_buf;

  mcu_channel_aligner_chroma_upsample u_cb_up (
    .c    (cb_buf),
    .mode (mode_q),
    .k    (k_d),
    .up   (cb_up)
  );

  mcu_channel_aligner_chroma_upsample u_cr_up (
    .c    (cr_src),
    .mode (mode_q),
    .k    (k_d),
    .up   (cr_up)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_idx   <= '0;
      mcu_last  <= 1'b0;
      seq_err   <= 1'b0;
      y_out     <= '0;
      cb_out    <= '0;
      cr_out    <= '0;
    end else begin
      in_ready  <= (state_d == ST_COLLECT);
      out_valid <= (state_d == ST_EMIT);
      out_idx   <= k_d;
      mcu_last  <= last_d;
      seq_err   <= err_d;
      if (load_out) begin
        y_out  <= ybuf[k_d];
        cb_out <= cb_up;
        cr_out <= cr_up;
      end
    end
  end

endmodule

// File: tb/tb_mcu_channel_aligner.sv
// Self-checking bench for mcu_channel_aligner: directed scenarios plus random
// MCUs compared against an arithmetic model of the chroma alignment rules.
module tb_mcu_channel_aligner;
  import mcu_channel_aligner_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] mode_in;
  block_t     blk_in;
  logic [1:0] ch_in;
  logic       in_valid;
  logic       in_ready;
  block_t     y_out, cb_out, cr_out;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       mcu_last;
  logic       seq_err;

  int compared   = 0;
  int mismatched = 0;

  block_t     cap_y [8];
  block_t     cap_cb[8];
  block_t     cap_cr[8];
  logic [1:0] cap_idx [8];
  logic       cap_last[8];
  int         cap_n;

  mcu_channel_aligner dut (
    .clk       (clk),
    .rst       (rst),
    .mode_in   (mode_in),
    .blk_in    (blk_in),
    .ch_in     (ch_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .cb_out    (cb_out),
    .cr_out    (cr_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .mcu_last  (mcu_last),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic block_t fill(input logic [7:0] v);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[3'(r)][3'(c)] = v;
    return b;
  endfunction

  function automatic block_t rand_block();
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[3'(r)][3'(c)] = 8'($urandom);
    return b;
  endfunction

  function automatic int ny_of(input int mode);
    if (mode == 1) return 2;
    if (mode == 2) return 4;
    return 1;
  endfunction

  // Chroma seen by Y block k, straight from the alignment formulas
  function automatic block_t up_model(input block_t c, input int mode, input int k);
    block_t o;
    for (int r = 0; r < 8; r++) begin
      for (int col = 0; col < 8; col++) begin
        int sr, sc;
        sr = r;
        sc = col;
        if (mode == 1) begin
          sc = col / 2 + 4 * k;
        end else if (mode == 2) begin
          sr = r / 2 + 4 * (k / 2);
          sc = col / 2 + 4 * (k % 2);
        end
        o[3'(r)][3'(col)] = c[3'(sr)][3'(sc)];
      end
    end
    return o;
  endfunction

  task automatic send(input logic [1:0] ch, input block_t b, output logic err);
    @(negedge clk);
    ch_in    = ch;
    blk_in   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err      = seq_err;
  endtask

  task automatic capture(input int budget, input bit rand_ready);
    cap_n = 0;
    repeat (budget) begin
      @(negedge clk);
      out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        if (cap_n < 8) begin
          cap_y[cap_n]    = y_out;
          cap_cb[cap_n]   = cb_out;
          cap_cr[cap_n]   = cr_out;
          cap_idx[cap_n]  = out_idx;
          cap_last[cap_n] = mcu_last;
        end
        cap_n++;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode_in = 2'd0; ch_in = 2'd0; blk_in = '0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (out_idx !== 2'd0) begin mismatched++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    compared++; if (mcu_last !== 1'b0) begin mismatched++; $display("FAIL reset_mcu_last: got %b want 0", mcu_last); end
    compared++; if (seq_err !== 1'b0) begin mismatched++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    compared++; if (y_out !== '0) begin mismatched++; $display("FAIL reset_y_out: got %h want 0", y_out); end
    compared++; if (cb_out !== '0) begin mismatched++; $display("FAIL reset_cb_out: got %h want 0", cb_out); end
    compared++; if (cr_out !== '0) begin mismatched++; $display("FAIL reset_cr_out: got %h want 0", cr_out); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_420();
    block_t ys[4];
    block_t cb, cr;
    logic e;
    mode_in = 2'd2;
    for (int k = 0; k < 4; k++) ys[k] = fill(8'(10 * (k + 1)));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cb[3'(r)][3'(c)] = 8'(16 * r + c);
    cr = fill(8'd200);
    for (int k = 0; k < 4; k++) begin
      send(CH_Y, ys[k], e);
      compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL 420_y%0d_err: got %b want 0", k, e); end
    end
    send(CH_CB, cb, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL 420_cb_err: got %b want 0", e); end
    send(CH_CR, cr, e);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL 420_latency_valid: got %b want 1", out_valid); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL 420_emit_in_ready: got %b want 0", in_ready); end
    capture(10, 1'b0);
    compared++; if (cap_n !== 4) begin mismatched++; $display("FAIL 420_count: got %0d want 4", cap_n); end
    for (int k = 0; k < 4; k++) begin
      compared++; if (cap_idx[k] !== 2'(k)) begin mismatched++; $display("FAIL 420_idx%0d: got %0d want %0d", k, cap_idx[k], k); end
      compared++; if (cap_last[k] !== (k == 3)) begin mismatched++; $display("FAIL 420_last%0d: got %b want %b", k, cap_last[k], k == 3); end
      compared++; if (cap_y[k] !== ys[k]) begin mismatched++; $display("FAIL 420_y%0d: got %h want %h", k, cap_y[k], ys[k]); end
      compared++; if (cap_cb[k] !== up_model(cb, 2, k)) begin mismatched++; $display("FAIL 420_cb%0d: got %h want %h", k, cap_cb[k], up_model(cb, 2, k)); end
      compared++; if (cap_cr[k] !== up_model(cr, 2, k)) begin mismatched++; $display("FAIL 420_cr%0d: got %h want %h", k, cap_cr[k], up_model(cr, 2, k)); end
    end
    compared++; if (cap_cb[3][7][7] !== 8'd119) begin mismatched++; $display("FAIL 420_spot_k3: got %0d want 119", cap_cb[3][7][7]); end
    compared++; if (cap_cb[1][0][0] !== 8'd4) begin mismatched++; $display("FAIL 420_spot_k1: got %0d want 4", cap_cb[1][0][0]); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL 420_after_in_ready: got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL 420_after_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_422();
    block_t ys[2];
    block_t cb, cr;
    logic e;
    int bad;
    mode_in = 2'd1;
    for (int k = 0; k < 2; k++) ys[k] = rand_block();
    cb = rand_block();
    cr = rand_block();
    for (int k = 0; k < 2; k++) send(CH_Y, ys[k], e);
    send(CH_CB, cb, e);
    send(CH_CR, cr, e);
    capture(8, 1'b0);
    compared++; if (cap_n !== 2) begin mismatched++; $display("FAIL 422_count: got %0d want 2", cap_n); end
    for (int k = 0; k < 2; k++) begin
      compared++; if (cap_last[k] !== (k == 1)) begin mismatched++; $display("FAIL 422_last%0d: got %b want %b", k, cap_last[k], k == 1); end
      compared++; if (cap_y[k] !== ys[k]) begin mismatched++; $display("FAIL 422_y%0d: got %h want %h", k, cap_y[k], ys[k]); end
      compared++; if (cap_cr[k] !== up_model(cr, 1, k)) begin mismatched++; $display("FAIL 422_cr%0d: got %h want %h", k, cap_cr[k], up_model(cr, 1, k)); end
    end
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (cap_cb[1][3'(r)][3'(c)] !== cb[3'(r)][3'((c >> 1) + 4)]) bad++;
    compared++; if (bad != 0) begin mismatched++; $display("FAIL 422_cb_k1: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_444_backpressure();
    block_t y0, cb, cr, y1;
    logic e;
    mode_in   = 2'd0;
    out_ready = 1'b0;
    y0 = rand_block(); cb = rand_block(); cr = rand_block(); y1 = rand_block();
    send(CH_Y, y0, e);
    send(CH_CB, cb, e);
    send(CH_CR, cr, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ch_in = CH_Y; blk_in = fill(8'd77);
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      compared++; if (mcu_last !== 1'b1) begin mismatched++; $display("FAIL bp_last%0d: got %b want 1", i, mcu_last); end
      compared++; if (seq_err !== 1'b0) begin mismatched++; $display("FAIL bp_seq_err%0d: got %b want 0", i, seq_err); end
      compared++; if (y_out !== y0) begin mismatched++; $display("FAIL bp_y%0d: got %h want %h", i, y_out, y0); end
      compared++; if (cb_out !== cb) begin mismatched++; $display("FAIL bp_cb%0d: got %h want %h", i, cb_out, cb); end
      compared++; if (cr_out !== cr) begin mismatched++; $display("FAIL bp_cr%0d: got %h want %h", i, cr_out, cr); end
    end
    // Handshake with a stray input still asserted; it must not be taken
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_done_valid: got %b want 0", out_valid); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_done_in_ready: got %b want 1", in_ready); end
    send(CH_Y, y1, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL b2b_y_err: got %b want 0", e); end
    send(CH_CB, cb, e);
    send(CH_CR, cr, e);
    capture(6, 1'b0);
    compared++; if (cap_n !== 1) begin mismatched++; $display("FAIL b2b_count: got %0d want 1", cap_n); end
    compared++; if (cap_y[0] !== y1) begin mismatched++; $display("FAIL b2b_y: got %h want %h", cap_y[0], y1); end
  endtask

  task automatic test_seq_err();
    block_t ys[4];
    block_t cb, cr;
    logic e;
    mode_in = 2'd2;
    for (int k = 0; k < 4; k++) ys[k] = rand_block();
    cb = rand_block(); cr = rand_block();
    send(CH_Y, ys[0], e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL se_y0_err: got %b want 0", e); end
    send(CH_CB, cb, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL se_early_cb_err: got %b want 1", e); end
    for (int k = 1; k < 4; k++) begin
      send(CH_Y, ys[k], e);
      compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL se_y%0d_err: got %b want 0", k, e); end
    end
    send(CH_CB, cb, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL se_cb_err: got %b want 0", e); end
    send(CH_CR, cr, e);
    capture(10, 1'b0);
    compared++; if (cap_n !== 4) begin mismatched++; $display("FAIL se_count: got %0d want 4", cap_n); end
    for (int k = 0; k < 4; k++) begin
      compared++; if (cap_y[k] !== ys[k]) begin mismatched++; $display("FAIL se_y%0d: got %h want %h", k, cap_y[k], ys[k]); end
      compared++; if (cap_cb[k] !== up_model(cb, 2, k)) begin mismatched++; $display("FAIL se_cb%0d: got %h want %h", k, cap_cb[k], up_model(cb, 2, k)); end
    end
  endtask

  task automatic test_illegal();
    block_t y0, cb, cr;
    logic e;
    y0 = rand_block(); cb = rand_block(); cr = rand_block();
    mode_in = 2'd0;
    send(2'd3, rand_block(), e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL ill_ch3_start: got %b want 1", e); end
    mode_in = 2'd3;
    send(CH_Y, y0, e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL ill_rsvd_mode: got %b want 1", e); end
    mode_in = 2'd2;
    send(2'd3, rand_block(), e);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL ill_ch3_mid: got %b want 1", e); end
    send(CH_CB, cb, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL ill_cb_err: got %b want 0", e); end
    send(CH_CR, cr, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL ill_cr_err: got %b want 0", e); end
    capture(6, 1'b0);
    compared++; if (cap_n !== 1) begin mismatched++; $display("FAIL ill_count: got %0d want 1", cap_n); end
    compared++; if (cap_last[0] !== 1'b1) begin mismatched++; $display("FAIL ill_last: got %b want 1", cap_last[0]); end
    compared++; if (cap_y[0] !== y0) begin mismatched++; $display("FAIL ill_y: got %h want %h", cap_y[0], y0); end
    compared++; if (cap_cb[0] !== cb) begin mismatched++; $display("FAIL ill_cb: got %h want %h", cap_cb[0], cb); end
    compared++; if (cap_cr[0] !== cr) begin mismatched++; $display("FAIL ill_cr: got %h want %h", cap_cr[0], cr); end
  endtask

  task automatic test_reset_mid();
    block_t y0, cb, cr;
    logic e;
    mode_in = 2'd2;
    send(CH_Y, rand_block(), e);
    send(CH_Y, rand_block(), e);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    mode_in = 2'd0;
    y0 = rand_block(); cb = rand_block(); cr = rand_block();
    send(CH_Y, y0, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL rm_y_err: got %b want 0", e); end
    send(CH_CB, cb, e);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL rm_cb_err: got %b want 0", e); end
    send(CH_CR, cr, e);
    capture(8, 1'b0);
    compared++; if (cap_n !== 1) begin mismatched++; $display("FAIL rm_count: got %0d want 1", cap_n); end
    compared++; if (cap_y[0] !== y0) begin mismatched++; $display("FAIL rm_y: got %h want %h", cap_y[0], y0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int m, em, ny;
      block_t ys[4];
      block_t cb, cr;
      logic [1:0] exp_ch, bad_ch;
      logic e;
      m  = int'($urandom_range(3));
      em = (m == 3) ? 0 : m;
      ny = ny_of(em);
      for (int k = 0; k < 4; k++) ys[k] = rand_block();
      cb = rand_block(); cr = rand_block();
      for (int p = 0; p < ny + 2; p++) begin
        exp_ch = (p < ny) ? CH_Y : ((p == ny) ? CH_CB : CH_CR);
        mode_in = (p == 0) ? 2'(m) : 2'($urandom);
        if ($urandom_range(3) == 0) begin
          do bad_ch = 2'($urandom); while (bad_ch == exp_ch);
          send(bad_ch, rand_block(), e);
          compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL rnd%0d_drop_p%0d: got %b want 1", it, p, e); end
        end
        send(exp_ch, (p < ny) ? ys[p] : ((p == ny) ? cb : cr), e);
        compared++; if (e !== (p == 0 && m == 3)) begin mismatched++; $display("FAIL rnd%0d_err_p%0d: got %b want %b", it, p, e, p == 0 && m == 3); end
      end
      capture(30, 1'b1);
      compared++; if (cap_n !== ny) begin mismatched++; $display("FAIL rnd%0d_count: got %0d want %0d", it, cap_n, ny); end
      for (int k = 0; k < ny; k++) begin
        compared++; if (cap_idx[k] !== 2'(k) || cap_last[k] !== (k == ny - 1)) begin mismatched++; $display("FAIL rnd%0d_ctl%0d: got idx %0d last %b want idx %0d last %b", it, k, cap_idx[k], cap_last[k], k, k == ny - 1); end
        compared++; if (cap_y[k] !== ys[k]) begin mismatched++; $display("FAIL rnd%0d_y%0d: got %h want %h", it, k, cap_y[k], ys[k]); end
        compared++; if (cap_cb[k] !== up_model(cb, em, k)) begin mismatched++; $display("FAIL rnd%0d_cb%0d: got %h want %h", it, k, cap_cb[k], up_model(cb, em, k)); end
        compared++; if (cap_cr[k] !== up_model(cr, em, k)) begin mismatched++; $display("FAIL rnd%0d_cr%0d: got %h want %h", it, k, cap_cr[k], up_model(cr, em, k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_420();
    test_422();
    test_444_backpressure();
    test_seq_err();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mcu_channel_aligner.md
Name: mcu_channel_aligner

Overview:
- Successor to the fixed supersample + channel_buffer pair.
- Collects one MCU of dequantised, IDCT'd 8x8 blocks (Y blocks, then Cb, then Cr) in a runtime-selected chroma mode: 4:4:4, 4:2:2 or 4:2:0.
- Emits one aligned Y/Cb/Cr 8x8 triple per Y block, chroma nearest-neighbour upsampled, over a valid/ready handshake into YCbCr_to_RGB_8x8.
- Adds backpressure, a mode select and sequence-error detection.

Parameters:
- Q, 8, sample width in bits.
- MAX_Y, 4, maximum Y blocks per MCU. Must be 4 to support 4:2:0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- mode_in  in  2  chroma mode: 0 = 4:4:4, 1 = 4:2:2, 2 = 4:2:0, 3 = reserved. Sampled at first block of each MCU.
- blk_in  in  Q x [8][8]  input block.
- ch_in  in  2  channel of blk_in: 0 = Y, 1 = Cb, 2 = Cr, 3 = illegal.
- in_valid  in  1  blk_in/ch_in valid.
- in_ready  out  1  block accepted on in_valid && in_ready.
- y_out, cb_out, cr_out  out  Q x [8][8]  aligned output triple.
- out_valid  out  1  output triple valid.
- out_ready  in  1  consumer accepts on out_valid && out_ready.
- out_idx  out  2  index k of the Y block being emitted.
- mcu_last  out  1  high with the final triple of an MCU.
- seq_err  out  1  one-cycle pulse when an input block is dropped.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = COLLECT; counters and held mode cleared.
  - in_ready = 1; out_valid = 0; out_idx = 0; mcu_last = 0; seq_err = 0.
  - y_out/cb_out/cr_out = 0.
  - Reset mid-MCU discards all buffered blocks.
- nY per mode: 4:4:4 = 1, 4:2:2 = 2, 4:2:0 = 4. Reserved mode 3 is treated as 4:4:4 and also pulses seq_err at MCU start.
- COLLECT state:
  - in_ready = 1.
  - Expected sequence: nY Y blocks, then one Cb, then one Cr.
  - Mode is latched on the first accepted block of the MCU (ycnt == 0 and no chroma held).
  - An accepted Y block is stored in ybuf[ycnt]; ycnt increments.
  - Cb is accepted only when ycnt == nY; Cr only when Cb is held.
  - Any block whose channel does not match the expected channel, including ch_in == 3: block dropped, seq_err pulses the next cycle, state unchanged.
  - Acceptance of Cr moves the FSM to EMIT at that edge.
- EMIT state:
  - in_ready = 0.
  - out_valid = 1 from the cycle after Cr acceptance, i.e. latency 1 cycle from last input handshake to first output.
  - y_out = ybuf[k].
  - Chroma C = Cb or Cr, for output pixel (r, c):
    - 4:4:4: C[r][c]
    - 4:2:2: C[r][(c>>1) + 4k]
    - 4:2:0: C[(r>>1) + 4(k>>1)][(c>>1) + 4(k&1)], with k raster order: 0 TL, 1 TR, 2 BL, 3 BR.
  - Outputs hold stable while out_valid && !out_ready.
  - On handshake: k increments. When k == nY-1, mcu_last = 1, and the handshake returns the FSM to COLLECT, clears buffers and sets in_ready = 1 the next cycle.
- Simultaneous events:
  - No input is accepted in the cycle of the final output handshake (in_ready is still 0).
  - A mode_in change mid-MCU is ignored until the next MCU.
- Widths: all indexing is unsigned; no arithmetic on sample values; no rounding.

Decomposition:
- Shared package (sys_defs.svh): constants CH_Y/CH_CB/CH_CR and MODE_444/422/420; type BLOCK_T (Q x [8][8]); function n_y_blocks(mode).
- One combinational sub-module, chroma_upsample (in: block C, mode, k; out: upsampled 8x8), instantiated twice (Cb, Cr).
- FSM and storage stay in mcu_channel_aligner.

Test Plan:
- 4:2:0, out_ready = 1:
  - Stimulus: Y0..Y3 filled with 10, 20, 30, 40; Cb pixel = 16r + c; Cr = 200.
  - Response: 4 triples with out_idx 0..3, first one cycle after Cr; mcu_last only on k = 3.
  - Spot checks: k = 3 gives cb_out[7][7] = 16·7 + 7 = 119; k = 1 gives cb_out[0][0] = 4.
- 4:2:2: Y0, Y1, Cb, Cr.
  - Response: 2 outputs; k = 1 gives cb_out[r][c] = Cb[r][(c>>1) + 4]; mcu_last on k = 1.
- 4:4:4 backpressure:
  - Stimulus: out_ready held 0 for 5 cycles.
  - Response: out_valid stays 1, outputs stable, in_ready = 0 throughout; handshake, then in_ready = 1 the next cycle.
- Sequence error: in 4:2:0 send Y0, Cb.
  - Response: Cb dropped with a 1-cycle seq_err pulse. Then Y1..Y3, Cb, Cr produce a correct MCU.
- Illegal and reserved inputs:
  - ch_in = 3 pulses seq_err and leaves state unchanged.
  - mode_in = 3 at MCU start pulses seq_err and behaves as 4:4:4.
- Reset mid-MCU: after Y0, Y1 in 4:2:0, drive rst = 0 for 1 cycle.
  - Response: out_valid = 0 and in_ready = 1. A fresh 4:4:4 MCU then emits exactly one triple.
